// File: rtl/mipi_pkt_pkg.sv
// Shared constants, state encoding and sizing helper for the MIPI TX frame packer.
package mipi_pkt_pkg;

    localparam logic [47:0] SYNC_WORD = 48'h7E7E_7E7E_7E7E;
    localparam logic [7:0]  HDR_MAGIC = 8'hA5;
    localparam logic [15:0] TRL_MAGIC = 16'h7E81;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        SYNC,
        HDR,
        PAYLOAD,
        TRAILER
    } state_t;

    // Number of 48-bit payload words needed to carry dlen bytes.
    function automatic int calc_words(input int dlen);
        return (dlen + 5) / 6;
    endfunction

endpackage

// File: rtl/mipi_byte_sum6.sv
// Adds the six bytes of a 48-bit word to a 16-bit running sum, modulo 2^16.
module mipi_byte_sum6 (
    input  logic [15:0] sum_in,
    input  logic [47:0] word,
    output logic [15:0] sum_out
);

    always_comb begin
        sum_out = sum_in;
        for (int i = 0; i < 6; i++) begin
            sum_out = sum_out + {8'h00, word[8*i +: 8]};
        end
    end

endmodule

// File: rtl/mipi_frame_packer.sv
// Frames a captured DLEN-byte payload as sync/header/payload/trailer 48-bit words
// on the MIPI TX pixel bus, advancing one word per line_valid cycle.
module mipi_frame_packer
    import mipi_pkt_pkg::*;
#(
    parameter int DLEN = 512
) (
    input  logic              tx_pixel_clk,
    input  logic              rst_n,
    input  logic [DLEN*8-1:0] data,
    input  logic              data_available,
    input  logic              frame_start,
    input  logic              line_valid,
    output logic [63:0]       pixel_value,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int WORDS = calc_words(DLEN);
    localparam int PAD_W = WORDS * 48;
    localparam logic [15:0] DLEN16 = 16'(DLEN);
    localparam logic [15:0] LAST_IDX = 16'(WORDS - 1);

    state_t            state_q, state_d;
    logic [15:0]       idx_q, idx_d;
    logic [7:0]        seq_q, seq_d;
    logic [15:0]       csum_q, csum_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic [47:0]       pix_q, pix_d;
    logic              load, shift;

    logic [PAD_W-1:0]  shadow_q;
    logic [PAD_W-1:0]  shadow_ext;
    logic [PAD_W-1:0]  shadow_shl;
    logic [15:0]       csum_sum;

    // Payload is left-aligned in the shadow so the current word is always the top 48 bits.
    always_comb begin
        shadow_ext = '0;
        shadow_ext[PAD_W-1 -: DLEN*8] = data;
    end

    assign shadow_shl = shadow_q << 48;

    mipi_byte_sum6 u_sum (
        .sum_in  (csum_q),
        .word    (shadow_q[PAD_W-1 -: 48]),
        .sum_out (csum_sum)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        csum_d    = csum_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pix_d     = pix_q;
        load      = 1'b0;
        shift     = 1'b0;
        // The cycle done is high still counts as in flight for a new load.
        overrun_d = data_available & (busy_q | done_q);

        case (state_q)
            IDLE: begin
                if (data_available && !done_q) begin
                    load    = 1'b1;
                    csum_d  = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    pix_d   = '0;
                    state_d = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (frame_start) begin
                    pix_d   = SYNC_WORD;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (line_valid) begin
                    pix_d   = {HDR_MAGIC, seq_q, DLEN16, 16'h0000};
                    state_d = HDR;
                end
            end
            HDR: begin
                if (line_valid) begin
                    pix_d   = shadow_q[PAD_W-1 -: 48];
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (line_valid) begin
                    shift  = 1'b1;
                    csum_d = csum_sum;
                    if (idx_q == LAST_IDX) begin
                        pix_d   = {TRL_MAGIC, 16'h0000, csum_sum};
                        state_d = TRAILER;
                    end else begin
                        idx_d = idx_q + 16'd1;
                        pix_d = shadow_shl[PAD_W-1 -: 48];
                    end
                end
            end
            TRAILER: begin
                if (line_valid) begin
                    pix_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    seq_d   = seq_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            seq_q     <= '0;
            csum_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            pix_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
            csum_q    <= csum_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            pix_q     <= pix_d;
        end
    end

    // Shadow is pure data: only meaningful after a load, so it carries no reset.
    always_ff @(posedge tx_pixel_clk) begin
        if (load) begin
            shadow_q <= shadow_ext;
        end else if (shift) begin
            shadow_q <= shadow_shl;
        end
    end

    assign pixel_value = {16'h0000, pix_q};
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_mipi_frame_packer.sv
// Bench for mipi_frame_packer: two instances (DLEN=12 and DLEN=7, both two payload
// words) share control inputs and are checked against a byte-level packet model.
module tb_mipi_frame_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] data_a;
    logic [55:0] data_b;
    logic        data_available;
    logic        frame_start;
    logic        line_valid;
    logic [63:0] pv_a, pv_b;
    logic        busy_a, busy_b, done_a, done_b, ovr_a, ovr_b;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_seq  = 8'h00;
    logic [47:0] qa[$];
    logic [47:0] qb[$];

    typedef struct {
        logic        lv;
        logic [47:0] exp_a;
        logic [47:0] exp_b;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    mipi_frame_packer #(.DLEN(12)) dut_a (
        .tx_pixel_clk   (clk),
        .rst_n          (rst_n),
        .data           (data_a),
        .data_available (data_available),
        .frame_start    (frame_start),
        .line_valid     (line_valid),
        .pixel_value    (pv_a),
        .busy           (busy_a),
        .done           (done_a),
        .overrun        (ovr_a)
    );

    mipi_frame_packer #(.DLEN(7)) dut_b (
        .tx_pixel_clk   (clk),
        .rst_n          (rst_n),
        .data           (data_b),
        .data_available (data_available),
        .frame_start    (frame_start),
        .line_valid     (line_valid),
        .pixel_value    (pv_b),
        .busy           (busy_b),
        .done           (done_b),
        .overrun        (ovr_b)
    );

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs for one rising edge, return at the following falling edge.
    task automatic step(input logic lv, input logic fs, input logic da);
        line_valid     = lv;
        frame_start    = fs;
        data_available = da;
        @(negedge clk);
        line_valid     = 1'b0;
        frame_start    = 1'b0;
        data_available = 1'b0;
    endtask

    task automatic push(input int sel, input logic [47:0] w);
        if (sel == 0) qa.push_back(w);
        else          qb.push_back(w);
    endtask

    // Byte-level reference: d holds the payload left-aligned, byte 0 in d[95:88].
    task automatic push_pkt(input int sel, input int dlen, input logic [95:0] d, input logic [7:0] sq);
        logic [47:0] w;
        logic [15:0] cs;
        logic [7:0]  b;
        int          nw;
        nw = (dlen + 5) / 6;
        cs = 16'h0000;
        push(sel, 48'h7E7E_7E7E_7E7E);
        push(sel, {8'hA5, sq, 16'(dlen), 16'h0000});
        for (int k = 0; k < nw; k++) begin
            w = '0;
            for (int j = 0; j < 6; j++) begin
                int i;
                i = 6 * k + j;
                b = (i < dlen) ? d[95 - 8*i -: 8] : 8'h00;
                w = {w[39:0], b};
                cs = cs + {8'h00, b};
            end
            push(sel, w);
        end
        push(sel, {16'h7E81, 16'h0000, cs});
    endtask

    // mode: 0 streaming, 1 line_valid low/high alternating, 2 random line_valid.
    task automatic run_packet(input int mode, input int ovr_at, input int exp_cycles, input logic da_on_done);
        int          cyc;
        logic        lv, da;
        logic [95:0] save_a;
        cyc = 0;
        push_pkt(0, 12, data_a, exp_seq);
        push_pkt(1, 7, {data_b, 40'h0}, exp_seq);
        step(1'b0, 1'b0, 1'b1);
        chk1("busy_after_load_a", busy_a, 1'b1);
        chk1("busy_after_load_b", busy_b, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk64("wait_sof_idle_word", pv_a, 64'h0);
        step(1'b0, 1'b1, 1'b0);
        while (qa.size() > 0) begin
            if (cyc > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL packet_timeout: got %0d cycles required at most 200", cyc);
                qa.delete();
                qb.delete();
                break;
            end
            case (mode)
                0:       lv = 1'b1;
                1:       lv = (cyc % 2 == 1);
                default: lv = 1'($urandom_range(0, 1));
            endcase
            chk64("word_a", pv_a, {16'h0, qa[0]});
            chk64("word_b", pv_b, {16'h0, qb[0]});
            chk1("busy_in_packet", busy_a, 1'b1);
            chk1("overrun_a", ovr_a, (ovr_at >= 0) && (cyc - 1 == ovr_at));
            chk1("overrun_b", ovr_b, (ovr_at >= 0) && (cyc - 1 == ovr_at));
            da = (cyc == ovr_at);
            save_a = data_a;
            if (da) data_a = ~data_a;
            step(lv, 1'b0, da);
            data_a = save_a;
            if (lv) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            cyc++;
        end
        chk1("done_a", done_a, 1'b1);
        chk1("done_b", done_b, 1'b1);
        chk1("busy_after_trailer", busy_a, 1'b0);
        chk64("idle_word", pv_a, 64'h0);
        if (exp_cycles > 0) chk64("packet_cycles", 64'(cyc), 64'(exp_cycles));
        step(1'b0, 1'b0, da_on_done);
        chk1("done_cleared", done_a, 1'b0);
        chk1("overrun_on_done", ovr_a, da_on_done);
        chk1("busy_after_done", busy_a, 1'b0);
        if (da_on_done) begin
            step(1'b0, 1'b0, 1'b0);
            chk1("load_rejected_on_done", busy_a, 1'b0);
            chk1("overrun_single", ovr_a, 1'b0);
        end
        exp_seq = exp_seq + 8'd1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 48'h7E7E_7E7E_7E7E, 48'h7E7E_7E7E_7E7E};
        tbl[1] = '{1'b1, 48'hA500_000C_0000, 48'hA500_0007_0000};
        tbl[2] = '{1'b1, 48'h0102_0304_0506, 48'hFFFF_FFFF_FFFF};
        tbl[3] = '{1'b1, 48'h0708_090A_0B0C, 48'hFF00_0000_0000};
        tbl[4] = '{1'b1, 48'h7E81_0000_004E, 48'h7E81_0000_06F9};

        rst_n          = 1'b0;
        data_available = 1'b0;
        frame_start    = 1'b0;
        line_valid     = 1'b0;
        data_a         = 96'h0102_0304_0506_0708_090A_0B0C;
        data_b         = 56'hFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        chk64("reset_pixel", pv_a, 64'h0);
        chk1("reset_busy", busy_a, 1'b0);
        chk1("reset_done", done_a, 1'b0);
        chk1("reset_overrun", ovr_a, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Streaming packet against the literal vector table.
        step(1'b0, 1'b0, 1'b1);
        chk1("tbl_busy", busy_a, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk64("tbl_word_a", pv_a, {16'h0, tbl[i].exp_a});
            chk64("tbl_word_b", pv_b, {16'h0, tbl[i].exp_b});
            chk1("tbl_done_low", done_a, 1'b0);
            step(tbl[i].lv, 1'b0, 1'b0);
        end
        chk1("tbl_done_a", done_a, 1'b1);
        chk1("tbl_done_b", done_b, 1'b1);
        chk1("tbl_busy_end", busy_a, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk1("tbl_done_pulse", done_a, 1'b0);
        exp_seq = 8'h01;

        // Second packet (seq 1) with alternating line_valid, same data as streaming case.
        run_packet(1, -1, 10, 1'b0);

        // Overrun mid-packet, random data.
        data_a = {$urandom, $urandom, $urandom};
        data_b = 56'({$urandom, $urandom});
        run_packet(0, 2, 5, 1'b0);

        // Random line_valid stalls, load attempted in the done cycle.
        data_a = {$urandom, $urandom, $urandom};
        data_b = 56'({$urandom, $urandom});
        run_packet(2, -1, 0, 1'b1);

        // Fill out to 256 packets, then two more to cross the sequence wrap.
        for (int p = 4; p < 258; p++) begin
            data_a = {$urandom, $urandom, $urandom};
            data_b = 56'({$urandom, $urandom});
            run_packet(0, -1, 5, 1'b0);
        end

        // Asynchronous reset in the middle of the payload.
        data_a = {$urandom, $urandom, $urandom};
        data_b = 56'({$urandom, $urandom});
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk1("busy_before_reset", busy_a, 1'b1);
        chk64("payload_before_reset", pv_a, {16'h0, data_a[47:0]});
        #2 rst_n = 1'b0;
        #1;
        chk64("reset_mid_pixel_a", pv_a, 64'h0);
        chk64("reset_mid_pixel_b", pv_b, 64'h0);
        chk1("reset_mid_busy_a", busy_a, 1'b0);
        chk1("reset_mid_busy_b", busy_b, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_seq = 8'h00;
        step(1'b0, 1'b0, 1'b0);
        run_packet(0, -1, 5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
